// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings and helpers for the pipeline hazard controller
package pipeline_pkg;

    typedef enum logic [1:0] {
        WSEL_DMEM = 2'b00,
        WSEL_ALU  = 2'b01,
        WSEL_PC8  = 2'b10
    } wdata_sel_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXE = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } ctrl_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // A load in EXE cannot forward yet; it falls through to the MEM/WB candidates.
    function automatic fwd_sel_t fwd_pick(
        input logic       used,
        input logic [4:0] addr,
        input logic       exe_we,
        input logic [4:0] exe_waddr,
        input logic [1:0] exe_sel,
        input logic       mem_we,
        input logic [4:0] mem_waddr,
        input logic       wb_we,
        input logic [4:0] wb_waddr
    );
        return (!used || addr == 5'd0)                                  ? FWD_RF  :
               (exe_we && exe_waddr == addr && exe_sel != WSEL_DMEM)   ? FWD_EXE :
               (mem_we && mem_waddr == addr)                           ? FWD_MEM :
               (wb_we && wb_waddr == addr)                             ? FWD_WB  : FWD_RF;
    endfunction

endpackage

// File: rtl/muldiv_latency_counter.sv
// muldiv_latency_counter: remaining EXE occupancy of a mul/div, saturating at zero
module muldiv_latency_counter #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_value,
    output logic         o_busy
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_value = r_count;
    assign o_busy  = (r_count != '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall, bubble and ID-stage forwarding control for a 5-stage MIPS pipe
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_id_rs_addr,
    input  logic [4:0] i_id_rt_addr,
    input  logic       i_id_rs_used,
    input  logic       i_id_rt_used,
    input  logic       i_id_muldiv_start,
    input  logic       i_id_muldiv_is_div,
    input  logic       i_exe_GPR_we,
    input  logic [4:0] i_exe_GPR_waddr,
    input  logic [1:0] i_exe_GPR_wdata_sel,
    input  logic       i_mem_GPR_we,
    input  logic [4:0] i_mem_GPR_waddr,
    input  logic       i_wb_GPR_we,
    input  logic [4:0] i_wb_GPR_waddr,
    input  logic       i_mem_dmem_req,
    input  logic       i_mem_dmem_ready,
    output logic       o_pc_ena,
    output logic       o_if_id_ena,
    output logic       o_id_exe_ena,
    output logic       o_exe_mem_ena,
    output logic       o_mem_wb_ena,
    output logic       o_id_exe_bubble,
    output logic       o_exe_mem_bubble,
    output logic [1:0] o_id_rs_fwd_sel,
    output logic [1:0] o_id_rt_fwd_sel,
    output logic       o_muldiv_busy
);

    localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    logic          w_busy;
    logic [CW-1:0] w_count;
    logic          w_load;
    logic          w_mem_wait;
    logic          w_load_use;
    logic          w_rs_lu;
    logic          w_rt_lu;
    ctrl_state_t   w_state;

    muldiv_latency_counter #(.W(CW)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_value (i_id_muldiv_is_div ? DIV_LOAD : MUL_LOAD),
        .o_value (w_count),
        .o_busy  (w_busy)
    );

    assign w_state    = w_busy ? MULDIV : RUN;
    assign w_mem_wait = i_mem_dmem_req && !i_mem_dmem_ready;
    assign w_rs_lu    = i_id_rs_used && i_id_rs_addr != 5'd0 && i_id_rs_addr == i_exe_GPR_waddr;
    assign w_rt_lu    = i_id_rt_used && i_id_rt_addr != 5'd0 && i_id_rt_addr == i_exe_GPR_waddr;
    // Load-use is masked while a mul/div holds the front end anyway.
    assign w_load_use = w_state == RUN && i_exe_GPR_we && i_exe_GPR_wdata_sel == WSEL_DMEM
                        && (w_rs_lu || w_rt_lu);
    assign w_load     = i_id_muldiv_start && o_id_exe_ena && !o_id_exe_bubble;

    always_comb begin
        o_pc_ena         = 1'b0;
        o_if_id_ena      = 1'b0;
        o_id_exe_ena     = 1'b0;
        o_exe_mem_ena    = 1'b0;
        o_mem_wb_ena     = 1'b0;
        o_id_exe_bubble  = 1'b0;
        o_exe_mem_bubble = 1'b0;
        o_id_rs_fwd_sel  = FWD_RF;
        o_id_rt_fwd_sel  = FWD_RF;
        if (!i_reset) begin
            o_id_rs_fwd_sel  = fwd_pick(i_id_rs_used, i_id_rs_addr, i_exe_GPR_we, i_exe_GPR_waddr,
                                        i_exe_GPR_wdata_sel, i_mem_GPR_we, i_mem_GPR_waddr,
                                        i_wb_GPR_we, i_wb_GPR_waddr);
            o_id_rt_fwd_sel  = fwd_pick(i_id_rt_used, i_id_rt_addr, i_exe_GPR_we, i_exe_GPR_waddr,
                                        i_exe_GPR_wdata_sel, i_mem_GPR_we, i_mem_GPR_waddr,
                                        i_wb_GPR_we, i_wb_GPR_waddr);
            o_exe_mem_ena    = !w_mem_wait;
            o_mem_wb_ena     = !w_mem_wait;
            o_id_exe_ena     = !w_mem_wait && w_state == RUN;
            o_pc_ena         = !w_mem_wait && w_state == RUN && !w_load_use;
            o_if_id_ena      = !w_mem_wait && w_state == RUN && !w_load_use;
            o_id_exe_bubble  = !w_mem_wait && w_load_use;
            o_exe_mem_bubble = !w_mem_wait && w_state == MULDIV;
        end
    end

    assign o_muldiv_busy = w_busy;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed-vector check of stalls, bubbles and forwarding
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_addr, rt_addr, exe_waddr, mem_waddr, wb_waddr;
    logic       rs_used, rt_used, md_start, md_div;
    logic       exe_we, mem_we, wb_we, dmem_req, dmem_ready;
    logic [1:0] exe_sel;
    logic       pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena;
    logic       id_exe_bubble, exe_mem_bubble, busy;
    logic [1:0] rs_fwd, rt_fwd;
    logic [7:0] ctrl;
    int         n_checks = 0;
    int         n_fail = 0;

    localparam logic [7:0] C_RUN  = 8'b11111_00_0;
    localparam logic [7:0] C_OFF  = 8'b00000_00_0;
    localparam logic [7:0] C_LU   = 8'b00111_10_0;
    localparam logic [7:0] C_MD   = 8'b00011_01_1;
    localparam logic [7:0] C_MDMW = 8'b00000_00_1;

    always #5 clk = ~clk;

    assign ctrl = {pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
                   id_exe_bubble, exe_mem_bubble, busy};

    pipeline_hazard_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_id_rs_addr        (rs_addr),
        .i_id_rt_addr        (rt_addr),
        .i_id_rs_used        (rs_used),
        .i_id_rt_used        (rt_used),
        .i_id_muldiv_start   (md_start),
        .i_id_muldiv_is_div  (md_div),
        .i_exe_GPR_we        (exe_we),
        .i_exe_GPR_waddr     (exe_waddr),
        .i_exe_GPR_wdata_sel (exe_sel),
        .i_mem_GPR_we        (mem_we),
        .i_mem_GPR_waddr     (mem_waddr),
        .i_wb_GPR_we         (wb_we),
        .i_wb_GPR_waddr      (wb_waddr),
        .i_mem_dmem_req      (dmem_req),
        .i_mem_dmem_ready    (dmem_ready),
        .o_pc_ena            (pc_ena),
        .o_if_id_ena         (if_id_ena),
        .o_id_exe_ena        (id_exe_ena),
        .o_exe_mem_ena       (exe_mem_ena),
        .o_mem_wb_ena        (mem_wb_ena),
        .o_id_exe_bubble     (id_exe_bubble),
        .o_exe_mem_bubble    (exe_mem_bubble),
        .o_id_rs_fwd_sel     (rs_fwd),
        .o_id_rt_fwd_sel     (rt_fwd),
        .o_muldiv_busy       (busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic idle();
        {rs_addr, rt_addr, exe_waddr, mem_waddr, wb_waddr} = '0;
        {rs_used, rt_used, md_start, md_div, exe_we, mem_we, wb_we} = '0;
        exe_sel = 2'b01;
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        check("reset_ctrl", ctrl, C_OFF);
        tick();
        reset = 1'b0;
        tick();
        check("run_after_reset", ctrl, C_RUN);

        exe_we = 1; exe_waddr = 5'd3; exe_sel = 2'b01; rs_addr = 5'd3; rs_used = 1;
        #1 check("fwd_exe_alu", {6'd0, rs_fwd}, 8'd1);
        check("fwd_exe_nostall", ctrl, C_RUN);
        mem_we = 1; mem_waddr = 5'd3;
        #1 check("fwd_prio_exe_mem", {6'd0, rs_fwd}, 8'd1);
        rs_used = 0;
        #1 check("fwd_unused", {6'd0, rs_fwd}, 8'd0);
        idle(); exe_we = 1; rs_used = 1;
        #1 check("fwd_reg0", {6'd0, rs_fwd}, 8'd0);
        idle(); exe_we = 1; exe_waddr = 5'd4; exe_sel = 2'b10; rt_addr = 5'd4; rt_used = 1;
        #1 check("fwd_exe_pc8", {6'd0, rt_fwd}, 8'd1);
        idle(); mem_we = 1; mem_waddr = 5'd7; wb_we = 1; wb_waddr = 5'd7; rt_addr = 5'd7; rt_used = 1;
        #1 check("fwd_mem_over_wb", {6'd0, rt_fwd}, 8'd2);
        mem_we = 0;
        #1 check("fwd_wb", {6'd0, rt_fwd}, 8'd3);
        wb_we = 0;
        #1 check("fwd_none", {6'd0, rt_fwd}, 8'd0);

        idle(); exe_we = 1; exe_waddr = 5'd5; exe_sel = 2'b00; rt_addr = 5'd5; rt_used = 1;
        #1 check("load_use_stall", ctrl, C_LU);
        check("load_use_fwd", {6'd0, rt_fwd}, 8'd0);
        rt_used = 0;
        #1 check("load_unused_nostall", ctrl, C_RUN);
        rt_used = 1;
        tick();
        exe_we = 0; mem_we = 1; mem_waddr = 5'd5;
        #1 check("load_in_mem_run", ctrl, C_RUN);
        check("load_in_mem_fwd", {6'd0, rt_fwd}, 8'd2);

        idle(); exe_we = 1; exe_waddr = 5'd6; exe_sel = 2'b00; rs_addr = 5'd6; rs_used = 1;
        md_start = 1; md_div = 1;
        #1 check("start_under_lu", ctrl, C_LU);
        tick();
        idle();
        #1 check("start_under_lu_rejected", ctrl, C_RUN);

        md_start = 1; md_div = 1;
        #1 check("div_issue", ctrl, C_RUN);
        tick();
        idle();
        exe_we = 1; exe_waddr = 5'd5; exe_sel = 2'b00; rt_addr = 5'd5; rt_used = 1;
        for (int i = 0; i < 31; i++) begin
            #1 check($sformatf("div_busy_%0d", i), ctrl, C_MD);
            tick();
        end
        idle();
        #1 check("div_done", ctrl, C_RUN);
        tick();

        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mem_wait_%0d", i), ctrl, C_OFF);
            tick();
        end
        dmem_ready = 1;
        #1 check("mem_ready", ctrl, C_RUN);
        tick();
        idle();

        md_start = 1;
        #1 check("mul_issue", ctrl, C_RUN);
        tick();
        idle();
        #1 check("mul_busy_1", ctrl, C_MD);
        tick();
        dmem_req = 1;
        #1 check("mul_memwait_2", ctrl, C_MDMW);
        tick();
        #1 check("mul_memwait_3", ctrl, C_MDMW);
        tick();
        dmem_ready = 1;
        #1 check("mul_leaves_4", ctrl, C_RUN);
        tick();
        idle();

        md_start = 1;
        tick();
        idle();
        #1 check("mul_busy_before_reset", ctrl, C_MD);
        reset = 1'b1;
        #1 check("reset_mid_mul", ctrl, C_OFF);
        tick();
        reset = 1'b0;
        tick();
        check("mul_aborted", ctrl, C_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
